// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the 5-stage MIPS datapath.
// Stall holds the stage, flush inserts a NOP bubble, and saturating counters track both events.
module if_id_stage_reg #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PC_W-1:0]    pc_plus4_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_plus4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [5:0]         opcode_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         shamt_o,
    output logic [5:0]         funct_o,
    output logic [15:0]        imm16_o,
    output logic [25:0]        jaddr_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic               vld_p1;
    logic [PC_W-1:0]    pc_plus4_p1;
    logic [INSTR_W-1:0] instr_p1;
    logic [CNT_W-1:0]   stall_cnt_p1;
    logic [CNT_W-1:0]   flush_cnt_p1;

    // IF -> ID boundary: flush outranks stall, stall outranks capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1       <= 1'b0;
            pc_plus4_p1  <= '0;
            instr_p1     <= '0;
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else if (flush_i) begin
            vld_p1       <= 1'b0;
            pc_plus4_p1  <= '0;
            instr_p1     <= '0;
            flush_cnt_p1 <= sat_inc(flush_cnt_p1);
        end else if (stall_i) begin
            stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end else begin
            vld_p1      <= 1'b1;
            pc_plus4_p1 <= pc_plus4_i;
            instr_p1    <= instr_i;
        end
    end

    assign valid_o     = vld_p1;
    assign pc_plus4_o  = pc_plus4_p1;
    assign instr_o     = instr_p1;
    assign stall_cnt_o = stall_cnt_p1;
    assign flush_cnt_o = flush_cnt_p1;

    // Fixed MIPS field split; only a 32-bit instruction word is meaningful here.
    assign opcode_o = instr_p1[31:26];
    assign rs_o     = instr_p1[25:21];
    assign rt_o     = instr_p1[20:16];
    assign rd_o     = instr_p1[15:11];
    assign shamt_o  = instr_p1[10:6];
    assign funct_o  = instr_p1[5:0];
    assign imm16_o  = instr_p1[15:0];
    assign jaddr_o  = instr_p1[25:0];

endmodule
